// File: rtl/vram_defs.sv
// Constants shared by the VGA framebuffer and its rectangle-fill engine,
// plus the fill engine's state encoding.
package vram_defs;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 100;
  localparam int VRAM_ADDR_W = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine: clips one command to the screen and streams one
// VRAM write per clock in raster order on the framebuffer's CPU-side port.
module vram_rect_fill #(
  parameter int SCREEN_W = vram_defs::SCREEN_W,
  parameter int SCREEN_H = vram_defs::SCREEN_H,
  parameter int ADDR_W   = vram_defs::VRAM_ADDR_W
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_x,
  input  logic [6:0]        cmd_y,
  input  logic [7:0]        cmd_w,
  input  logic [6:0]        cmd_h,
  input  logic [7:0]        cmd_color,
  output logic              busy,
  output logic              done,
  output logic              cpu_wr,
  output logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_data
);
  import vram_defs::*;

  state_t            state_q, state_d;
  logic              ready_q, ready_d, busy_q, busy_d, done_q, done_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d, base_calc;
  logic [7:0]        data_q, data_d, x_q, x_d, w_q, w_d, color_q, color_d;
  logic [6:0]        y_q, y_d, h_q, h_d;
  logic [8:0]        wclip_q, wclip_d, col_q, col_d, xend;
  logic [7:0]        hclip_q, hclip_d, row_q, row_d, yend;

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    color_d   = color_q;
    wclip_d   = wclip_q;
    hclip_d   = hclip_q;
    base_d    = base_q;
    col_d     = col_q;
    row_d     = row_q;
    xend      = '0;
    yend      = '0;
    base_calc = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Clip against the screen edge; an origin already off-screen gives zero extent.
        xend = {1'b0, x_q} + {1'b0, w_q};
        if ({1'b0, x_q} >= 9'(SCREEN_W)) wclip_d = '0;
        else wclip_d = ((xend > 9'(SCREEN_W)) ? 9'(SCREEN_W) : xend) - {1'b0, x_q};
        yend = {1'b0, y_q} + {1'b0, h_q};
        if ({1'b0, y_q} >= 8'(SCREEN_H)) hclip_d = '0;
        else hclip_d = ((yend > 8'(SCREEN_H)) ? 8'(SCREEN_H) : yend) - {1'b0, y_q};
        // y*160 as shift-and-add
        base_calc = ADDR_W'({y_q, 7'b0}) + ADDR_W'({y_q, 5'b0});
        base_d    = base_calc;
        if (wclip_d == '0 || hclip_d == '0) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          wr_d    = 1'b1;
          addr_d  = base_calc + ADDR_W'(x_q);
          data_d  = color_q;
          col_d   = '0;
          row_d   = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (col_q == wclip_q - 9'd1) begin
          if (row_q == hclip_q - 8'd1) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            wr_d   = 1'b1;
            base_d = base_q + ADDR_W'(SCREEN_W);
            addr_d = base_q + ADDR_W'(SCREEN_W) + ADDR_W'(x_q);
            col_d  = '0;
            row_d  = row_q + 8'd1;
          end
        end else begin
          wr_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          col_d  = col_q + 9'd1;
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Command fields and walk counters are always rewritten before use.
  always_ff @(posedge cpu_clk) begin
    x_q     <= x_d;
    y_q     <= y_d;
    w_q     <= w_d;
    h_q     <= h_d;
    color_q <= color_d;
    wclip_q <= wclip_d;
    hclip_q <= hclip_d;
    base_q  <= base_d;
    col_q   <= col_d;
    row_q   <= row_d;
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cpu_wr    = wr_q;
  assign cpu_addr  = addr_q;
  assign cpu_data  = data_q;

endmodule

// File: tb/tb_vram_rect_fill.sv
// Bench for vram_rect_fill: directed and random fill commands checked
// cycle by cycle against an expected-address list built from the clip rules.
module tb_vram_rect_fill;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [7:0]  cmd_color;
  logic        busy, done, cpu_wr;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_data;

  int total = 0;
  int bad   = 0;

  vram_rect_fill dut (
    .cpu_clk  (cpu_clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x    (cmd_x),
    .cmd_y    (cmd_y),
    .cmd_w    (cmd_w),
    .cmd_h    (cmd_h),
    .cmd_color(cmd_color),
    .busy     (busy),
    .done     (done),
    .cpu_wr   (cpu_wr),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one command and check every cycle until cmd_ready returns.
  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input int color, input bit inject);
    int q[$];
    int xe, ye, p, guard;
    xe = (x + w > 160) ? 160 : x + w;
    ye = (y + h > 100) ? 100 : y + h;
    for (int r = y; r < ye; r++)
      for (int c = x; c < xe; c++)
        q.push_back(r * 160 + c);
    p = q.size();

    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge cpu_clk);
      guard++;
    end
    chk("ready_before_cmd", int'(cmd_ready), 1);

    cmd_valid = 1'b1;
    cmd_x     = 8'(x);
    cmd_y     = 7'(y);
    cmd_w     = 8'(w);
    cmd_h     = 7'(h);
    cmd_color = 8'(color);
    @(negedge cpu_clk);
    cmd_valid = 1'b0;
    chk("setup_busy",  int'(busy), 1);
    chk("setup_ready", int'(cmd_ready), 0);
    chk("setup_wr",    int'(cpu_wr), 0);
    chk("setup_done",  int'(done), 0);

    for (int k = 0; k < p; k++) begin
      @(negedge cpu_clk);
      chk("fill_wr",   int'(cpu_wr), 1);
      chk("fill_addr", int'(cpu_addr), q[k]);
      chk("fill_data", int'(cpu_data), color);
      chk("fill_done", int'(done), 0);
      if (inject) chk("fill_ready", int'(cmd_ready), 0);
      if (inject && k == 2) begin
        cmd_valid = 1'b1;
        cmd_x     = 8'd3;
        cmd_y     = 7'd50;
        cmd_w     = 8'd7;
        cmd_h     = 7'd7;
        cmd_color = 8'(~color);
      end
      if (k == 5) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;

    @(negedge cpu_clk);
    chk("done_pulse", int'(done), 1);
    chk("done_wr",    int'(cpu_wr), 0);
    chk("done_busy",  int'(busy), 1);
    if (p > 0) begin
      chk("hold_addr", int'(cpu_addr), q[p-1]);
      chk("hold_data", int'(cpu_data), color);
    end

    @(negedge cpu_clk);
    chk("idle_ready", int'(cmd_ready), 1);
    chk("idle_busy",  int'(busy), 0);
    chk("idle_done",  int'(done), 0);
    chk("idle_wr",    int'(cpu_wr), 0);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;
    @(negedge cpu_clk);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_wr",    int'(cpu_wr), 0);
    chk("rst_addr",  int'(cpu_addr), 0);
    chk("rst_data",  int'(cpu_data), 0);
    @(negedge cpu_clk);
    reset = 1'b0;
    @(negedge cpu_clk);

    run_cmd(10, 5, 3, 2, 8'h1C, 1'b0);
    run_cmd(158, 99, 10, 10, 8'h03, 1'b0);
    run_cmd(200, 10, 5, 5, 8'h44, 1'b0);
    run_cmd(10, 100, 5, 5, 8'h45, 1'b0);
    run_cmd(20, 20, 0, 5, 8'h46, 1'b0);
    run_cmd(20, 20, 5, 0, 8'h47, 1'b0);
    run_cmd(30, 40, 12, 4, 8'hA5, 1'b1);
    run_cmd(0, 0, 160, 100, 8'hE0, 1'b0);

    for (int i = 0; i < 10; i++)
      run_cmd($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 40),
              $urandom_range(0, 20), $urandom_range(0, 255), 1'b0);

    // Reset in the middle of a two-row fill.
    cmd_valid = 1'b1;
    cmd_x     = 8'd0;
    cmd_y     = 7'd0;
    cmd_w     = 8'd160;
    cmd_h     = 7'd2;
    cmd_color = 8'h77;
    @(negedge cpu_clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge cpu_clk);
    chk("pre_rst_wr",   int'(cpu_wr), 1);
    chk("pre_rst_addr", int'(cpu_addr), 4);
    reset = 1'b1;
    #1;
    chk("async_rst_wr",    int'(cpu_wr), 0);
    chk("async_rst_busy",  int'(busy), 0);
    chk("async_rst_ready", int'(cmd_ready), 1);
    chk("async_rst_addr",  int'(cpu_addr), 0);
    chk("async_rst_data",  int'(cpu_data), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk);
      chk("rst_no_done", int'(done), 0);
      chk("rst_no_wr",   int'(cpu_wr), 0);
    end
    reset = 1'b0;
    @(negedge cpu_clk);
    chk("post_rst_done", int'(done), 0);
    run_cmd(0, 0, 1, 1, 8'h5A, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
